instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/fetch_pkg.sv | 14 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/instr_prefetch.sv | 128 ++++++++++++
 tb/tb_instr_prefetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: prefetch FSM encoding, instruction width and default reset PC.
package fetch_pkg;

    localparam int INST_WIDTH       = 32;
    localparam int DEFAULT_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush, occupancy count and a zeroed head when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // A pop frees the slot this cycle, so push is allowed while full if popping.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: one-outstanding-request fetch FSM feeding a decode FIFO.
// Optional perf counters enabled by defining INSTR_PREFETCH_PERF_EN.
module instr_prefetch
    import fetch_pkg::*;
#(
    parameter int MEM_DEPTH  = 8,
    parameter int DATA_WIDTH = INST_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = DEFAULT_RESET_PC,
    localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_data_valid,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef INSTR_PREFETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_RST  = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    fetch_state_e          state, state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc, drop_addr;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count, occ_next;

    // Redirect flushes the FIFO, so a same-cycle pop must not count.
    assign pop      = inst_valid && inst_ready && !redirect_valid;
    assign occ_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect_valid)
                    state_nxt = mem_data_valid ? REQ : DROP;
                else if (mem_data_valid)
                    state_nxt = (occ_next == CNT_W'(FIFO_DEPTH)) ? FULL : REQ;
            end
            FULL: if (redirect_valid || !fifo_full || pop) state_nxt = REQ;
            DROP: if (mem_data_valid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_addr      = fetch_pc;
        push          = 1'b0;
        case (state)
            REQ: begin
                mem_req_valid = 1'b1;
                push          = mem_data_valid && !redirect_valid;
            end
            DROP: begin
                mem_req_valid = 1'b1;
                mem_addr      = drop_addr;
            end
            default: ;
        endcase
    end

    // drop_addr keeps the abandoned request's address stable until its response lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc  <= PC_RST;
            drop_addr <= PC_RST;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_pc;
            else if (push)
                fetch_pc <= (fetch_pc == PC_LAST) ? '0 : fetch_pc + 1'b1;
            if (state == REQ && redirect_valid && !mem_data_valid)
                drop_addr <= fetch_pc;
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   ({fetch_pc, mem_rdata}),
        .pop     (pop),
        .flush   (redirect_valid),
        .rdata   ({inst_pc, inst_data}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign inst_valid = !fifo_empty;

`ifdef INSTR_PREFETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == FULL) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: table-driven stall/refill sequence plus redirect and reset corner cases.
module tb_instr_prefetch;
    import fetch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        mem_req_valid;
    logic [2:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_data_valid;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [2:0]  inst_pc;
    logic        redirect_valid;
    logic [2:0]  redirect_pc;
`ifdef INSTR_PREFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instr_prefetch #(
        .MEM_DEPTH  (8),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_req_valid  (mem_req_valid),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef INSTR_PREFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0]  pc;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic       ready;
        logic       exp_req;
        logic       chk_addr;
        logic [2:0] exp_addr;
        logic       exp_iv;
        logic [7:0] exp_fetch;
        logic [7:0] exp_stall;
    } vec_t;

    int   n_chk;
    int   n_err;
    int   pop_cnt;
    bit   mem_auto;
    int   inject_cnt;
    exp_t sb_q[$];
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: answers each new request one cycle later; inject_cnt forces a stray strobe.
    initial begin : responder
        bit         nxt_dv;
        logic [2:0] nxt_addr;
        int         inject_seen;
        inject_seen    = 0;
        mem_data_valid = 1'b0;
        mem_rdata      = 32'h0;
        forever begin
            @(negedge clk);
            nxt_dv   = 1'b0;
            nxt_addr = mem_addr;
            if (inject_cnt != inject_seen) begin
                nxt_dv      = 1'b1;
                inject_seen = inject_cnt;
            end else if (mem_auto && mem_req_valid && !mem_data_valid) begin
                nxt_dv = 1'b1;
            end
            @(posedge clk);
            #1;
            mem_data_valid = nxt_dv;
            mem_rdata      = nxt_dv ? (32'hA0 + {29'd0, nxt_addr}) : 32'h0;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
                pop_cnt++;
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL pop_unexpected: got pc %0d data %0h expected no pop", inst_pc, inst_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("pop_pc", {29'd0, inst_pc}, {29'd0, e.pc});
                    chk("pop_data", inst_data, e.data);
                end
            end
        end
    end

    task automatic do_reset();
        reset_n        = 1'b0;
        mem_auto       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 3'd0;
        sb_q.delete();
        pop_cnt = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_req(input logic [2:0] a, input logic dv, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (mem_req_valid && mem_addr == a && mem_data_valid == dv) ok = 1'b1;
        end
    endtask

    initial begin : main
        bit ok;
        n_chk = 0; n_err = 0; pop_cnt = 0; mem_auto = 1'b0; inject_cnt = 0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 3'd0;

        // {ready, exp_req, chk_addr, exp_addr, exp_iv, exp_fetch, exp_stall}, one row per cycle after release
        tbl = '{
            '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0},
            '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'd0, 8'd0},
            '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'd0, 8'd0},
            '{1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'd1, 8'd0},
            '{1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 8'd1, 8'd0},
            '{1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 8'd2, 8'd0},
            '{1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 8'd2, 8'd0},
            '{1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 8'd3, 8'd0},
            '{1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 8'd3, 8'd0},
            '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'd4, 8'd0},
            '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'd4, 8'd1},
            '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'd4, 8'd2},
            '{1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'd4, 8'd3},
            '{1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'd4, 8'd3},
            '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'd5, 8'd3},
            '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'd5, 8'd4}
        };

        // reset values
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_addr", {29'd0, mem_addr}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_pc", {29'd0, inst_pc}, 32'd0);

        // backpressure: fill to FULL, one pop, refill
        do_reset();
        mem_auto = 1'b1;
        sb_q.push_back('{pc: 3'd0, data: 32'hA0});
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            inst_ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("full_c%0d_req", i), {31'd0, mem_req_valid}, {31'd0, tbl[i].exp_req});
            if (tbl[i].chk_addr)
                chk($sformatf("full_c%0d_addr", i), {29'd0, mem_addr}, {29'd0, tbl[i].exp_addr});
            chk($sformatf("full_c%0d_iv", i), {31'd0, inst_valid}, {31'd0, tbl[i].exp_iv});
`ifdef INSTR_PREFETCH_PERF_EN
            chk($sformatf("full_c%0d_perf_fetch", i), perf_fetch_cnt, {24'd0, tbl[i].exp_fetch});
            chk($sformatf("full_c%0d_perf_stall", i), perf_stall_cnt, {24'd0, tbl[i].exp_stall});
`endif
        end
        chk("full_sb_drained", sb_q.size(), 32'd0);

        // streaming with wrap: pc 0..7,0
        do_reset();
        mem_auto   = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 9; i++)
            sb_q.push_back('{pc: 3'(i % 8), data: 32'hA0 + 32'(i % 8)});
        for (int i = 0; i < 80 && pop_cnt < 9; i++) @(negedge clk);
        @(posedge clk);
        #1 inst_ready = 1'b0;
        chk("stream_pop_count", pop_cnt, 32'd9);
        chk("stream_sb_drained", sb_q.size(), 32'd0);

        // redirect to 5 while request for 2 is outstanding
        do_reset();
        mem_auto = 1'b1;
        wait_req(3'd2, 1'b0, ok);
        chk("drop_found_req2", {31'd0, ok}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 3'd5;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("drop_held_req", {31'd0, mem_req_valid}, 32'd1);
        chk("drop_held_addr", {29'd0, mem_addr}, 32'd2);
        chk("drop_flushed_iv", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("drop_next_req", {31'd0, mem_req_valid}, 32'd1);
        chk("drop_next_addr", {29'd0, mem_addr}, 32'd5);
        chk("drop_resp_ignored_iv", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("drop_still_empty", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("drop_new_iv", {31'd0, inst_valid}, 32'd1);
        chk("drop_new_pc", {29'd0, inst_pc}, 32'd5);
        chk("drop_new_data", inst_data, 32'hA5);

        // redirect to 3 coincident with the response for 1
        do_reset();
        mem_auto = 1'b1;
        wait_req(3'd1, 1'b1, ok);
        chk("coinc_found_resp1", {31'd0, ok}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 3'd3;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("coinc_req", {31'd0, mem_req_valid}, 32'd1);
        chk("coinc_addr", {29'd0, mem_addr}, 32'd3);
        chk("coinc_no_push", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("coinc_still_empty", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("coinc_new_iv", {31'd0, inst_valid}, 32'd1);
        chk("coinc_new_pc", {29'd0, inst_pc}, 32'd3);
        chk("coinc_new_data", inst_data, 32'hA3);

        // reset mid-request, then a stray response right after release
        do_reset();
        mem_auto = 1'b1;
        wait_req(3'd2, 1'b0, ok);
        chk("rstmid_found_req2", {31'd0, ok}, 32'd1);
        #2 reset_n = 1'b0;
        mem_auto = 1'b0;
        #1;
        chk("rstmid_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rstmid_addr", {29'd0, mem_addr}, 32'd0);
        chk("rstmid_iv", {31'd0, inst_valid}, 32'd0);
        chk("rstmid_data", inst_data, 32'd0);
        @(posedge clk);
        #2 inject_cnt++;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid_idle_req", {31'd0, mem_req_valid}, 32'd0);
        chk("rstmid_idle_iv", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("rstmid_restart_req", {31'd0, mem_req_valid}, 32'd1);
        chk("rstmid_restart_addr", {29'd0, mem_addr}, 32'd0);
        chk("rstmid_restart_iv", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("rstmid_late_ignored", {31'd0, inst_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
